// File: rtl/adder_arbiter_pkg.sv
// Shared types and helpers for the adder arbiter.
//   state_t    : arbiter FSM states
//   id_width() : width of a requester index for a given requester count
//   rr_select(): round-robin winner search starting after the last grant
package adder_arbiter_pkg;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned RR_W    = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Lowest offset from (last + 1) mod n with a pending request wins.
    function automatic logic [RR_W-1:0] rr_select(input logic [MAX_REQ-1:0] req,
                                                  input logic [RR_W-1:0]    last,
                                                  input int unsigned        n);
        logic [RR_W-1:0] sel;
        logic [RR_W-1:0] idx;
        logic            found;
        sel   = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < MAX_REQ; off++) begin
            if (!found && off < n) begin
                idx = RR_W'((32'(last) + off + 32'd1) % n);
                if (req[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester-side bus of the adder arbiter.
//   i_req/i_A/i_B : per-requester request level and operands
//   o_gnt/o_done  : one-hot grant and completion pulses
//   o_C/o_id      : shared result and the requester owning it
//   o_busy        : operation in flight
interface adder_arbiter_if #(
    parameter int unsigned g_data_width = 8,
    parameter int unsigned g_num_req    = 4
);
    import adder_arbiter_pkg::*;

    localparam int unsigned ID_W = id_width(g_num_req);

    logic [g_num_req-1:0]                   i_req;
    logic [g_num_req-1:0][g_data_width-1:0] i_A;
    logic [g_num_req-1:0][g_data_width-1:0] i_B;
    logic [g_num_req-1:0]                   o_gnt;
    logic [g_num_req-1:0]                   o_done;
    logic [g_data_width:0]                  o_C;
    logic [ID_W-1:0]                        o_id;
    logic                                   o_busy;

    modport master (
        output i_req, i_A, i_B,
        input  o_gnt, o_done, o_C, o_id, o_busy
    );

    modport slave (
        input  i_req, i_A, i_B,
        output o_gnt, o_done, o_C, o_id, o_busy
    );
endinterface

// File: rtl/adder_arbiter_adder.sv
// Single-cycle registered unsigned adder shared by all requesters.
//   i_valid/i_A/i_B : operands, sampled when i_valid is high
//   o_valid/o_C     : result pulse one cycle later; o_C holds between results
module adder_arbiter_adder #(
    parameter int unsigned g_data_width = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic [g_data_width-1:0] i_A,
    input  logic [g_data_width-1:0] i_B,
    output logic                    o_valid,
    output logic [g_data_width:0]   o_C
);

    // Zero-extend both operands so the carry lands in the MSB.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_C     <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_C <= {1'b0, i_A} + {1'b0, i_B};
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of one shared adder.
//   i_clk, i_rst : clock and synchronous active-high reset
//   bus          : requester bus (requests, operands, grant/done, result, id, busy)
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int unsigned g_data_width = 8,
    parameter int unsigned g_num_req    = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    adder_arbiter_if.slave  bus
);

    localparam int unsigned ID_W = id_width(g_num_req);

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         last_q, last_d;
    logic [ID_W-1:0]         cur_q, cur_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [ID_W-1:0]         sel;
    logic [g_data_width-1:0] op_a_q, op_a_d;
    logic [g_data_width-1:0] op_b_q, op_b_d;
    logic [g_num_req-1:0]    gnt_q, gnt_d;
    logic [g_num_req-1:0]    done_c;
    logic                    add_valid_q, add_valid_d;
    logic                    add_o_valid;
    logic [g_data_width:0]   add_c;

    assign sel = ID_W'(rr_select(MAX_REQ'(bus.i_req), RR_W'(last_q), g_num_req));

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            last_q      <= ID_W'(g_num_req - 1);
            cur_q       <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            gnt_q       <= '0;
            add_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cur_q       <= cur_d;
            id_q        <= id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            gnt_q       <= gnt_d;
            add_valid_q <= add_valid_d;
        end
    end

    // Next-state logic; completion is keyed on the adder's o_valid.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cur_d       = cur_q;
        id_d        = id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        gnt_d       = '0;
        add_valid_d = 1'b0;
        done_c      = '0;

        // o_id moves together with the adder's result register.
        if (add_valid_q) begin
            id_d = cur_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (|bus.i_req) begin
                    state_d     = ST_BUSY;
                    last_d      = sel;
                    cur_d       = sel;
                    op_a_d      = bus.i_A[sel];
                    op_b_d      = bus.i_B[sel];
                    gnt_d       = g_num_req'(1) << sel;
                    add_valid_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (add_o_valid) begin
                    done_c  = g_num_req'(1) << cur_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    adder_arbiter_adder #(
        .g_data_width (g_data_width)
    ) u_adder (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (add_valid_q),
        .i_A     (op_a_q),
        .i_B     (op_b_q),
        .o_valid (add_o_valid),
        .o_C     (add_c)
    );

    assign bus.o_gnt  = gnt_q;
    assign bus.o_done = done_c;
    assign bus.o_C    = add_c;
    assign bus.o_id   = id_q;
    assign bus.o_busy = (state_q == ST_BUSY);

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: transaction-level model plus directed scenarios.
module tb_adder_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;
    localparam int unsigned IW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NR-1:0]         req;
    logic [NR-1:0][DW-1:0] a;
    logic [NR-1:0][DW-1:0] b;
    logic [NR-1:0]         oneshot;

    adder_arbiter_if #(.g_data_width(DW), .g_num_req(NR)) bus ();

    assign bus.i_req = req;
    assign bus.i_A   = a;
    assign bus.i_B   = b;

    adder_arbiter #(.g_data_width(DW), .g_num_req(NR)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int cycle  = 0;
    int glog[$];
    int glog_t[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation occupies the block for the grant edge plus two cycles.
    bit          m1_v, m2_v;
    logic [IW-1:0] m1_k, m2_k;
    int          m1_sum, m2_sum;
    int          m_last;
    int          m_C, m_id;

    always @(posedge clk) begin : model
        bit grant;
        logic [IW-1:0] k;
        grant = 1'b0;
        k     = '0;
        cycle++;
        if (rst) begin
            m1_v   = 1'b0;
            m2_v   = 1'b0;
            m_last = NR - 1;
            m_C    = 0;
            m_id   = 0;
        end else begin
            if (!m1_v && !m2_v) begin
                for (int off = 1; off <= NR; off++) begin
                    logic [IW-1:0] c;
                    c = IW'((m_last + off) % NR);
                    if (!grant && req[c]) begin
                        grant = 1'b1;
                        k     = c;
                    end
                end
            end
            m2_v   = m1_v;
            m2_k   = m1_k;
            m2_sum = m1_sum;
            if (m2_v) begin
                m_C  = m2_sum;
                m_id = int'(m2_k);
            end
            m1_v = grant;
            if (grant) begin
                m1_k   = k;
                m1_sum = int'(a[k]) + int'(b[k]);
                m_last = int'(k);
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt",  int'(bus.o_gnt),  m1_v ? (1 << m1_k) : 0);
            check("done", int'(bus.o_done), m2_v ? (1 << m2_k) : 0);
            check("C",    int'(bus.o_C),    m_C);
            check("id",   int'(bus.o_id),   m_id);
            check("busy", int'(bus.o_busy), (m1_v || m2_v) ? 1 : 0);
            if (bus.o_gnt != '0) begin
                for (int i = 0; i < NR; i++) begin
                    if (bus.o_gnt[i]) begin
                        glog.push_back(i);
                        glog_t.push_back(cycle);
                    end
                end
            end
        end
    end

    // Advance n cycles; one-shot requesters drop their request once granted.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NR; i++) begin
                if (oneshot[i] && bus.o_gnt[i]) begin
                    req[i]     = 1'b0;
                    oneshot[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_done(input int k, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            step(1);
            if (bus.o_done[k]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_done[%0d] actual=no_done expected=done within %0d cycles", k, max);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        a       = '0;
        b       = '0;
        oneshot = '0;
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        step(1);
        check("rst_busy", int'(bus.o_busy), 0);
        check("rst_C",    int'(bus.o_C),    0);
        check("rst_gnt",  int'(bus.o_gnt),  0);
        rst = 1'b0;
        step(1);

        // Single request with carry out.
        a[2] = 8'hFF; b[2] = 8'h01; req[2] = 1'b1; oneshot[2] = 1'b1;
        step(1);
        check("single_gnt", int'(bus.o_gnt), 'b0100);
        step(1);
        check("single_done", int'(bus.o_done), 'b0100);
        check("single_C",    int'(bus.o_C),    'h100);
        check("single_id",   int'(bus.o_id),   2);
        step(1);
        check("hold_done", int'(bus.o_done), 0);
        check("hold_C",    int'(bus.o_C),    'h100);
        step(2);

        // Operand corners.
        a[0] = 8'h00; b[0] = 8'h00; req[0] = 1'b1; oneshot[0] = 1'b1;
        wait_done(0, 8);
        check("zero_C", int'(bus.o_C), 0);
        step(1);
        a[1] = 8'h80; b[1] = 8'h80; req[1] = 1'b1; oneshot[1] = 1'b1;
        wait_done(1, 8);
        check("c80_C", int'(bus.o_C), 'h100);
        step(2);

        // All four held from reset: 0,1,2,3,0 at a 3-cycle cadence.
        a = {8'hF0, 8'h7F, 8'h33, 8'h01};
        b = {8'h20, 8'h81, 8'h44, 8'h02};
        req = 4'b1111;
        glog.delete(); glog_t.delete();
        pulse_reset();
        step(15);
        req = '0;
        step(4);
        check("rr_count", glog.size(), 5);
        if (glog.size() >= 5) begin
            check("rr_g0", glog[0], 0);
            check("rr_g1", glog[1], 1);
            check("rr_g2", glog[2], 2);
            check("rr_g3", glog[3], 3);
            check("rr_g4", glog[4], 0);
            check("rr_gap", glog_t[4] - glog_t[3], 3);
        end

        // Two held requesters alternate.
        glog.delete(); glog_t.delete();
        req = 4'b0011;
        pulse_reset();
        step(12);
        req = '0;
        step(4);
        if (glog.size() >= 4) begin
            check("alt_g0", glog[0], 0);
            check("alt_g1", glog[1], 1);
            check("alt_g2", glog[2], 0);
            check("alt_g3", glog[3], 1);
        end else begin
            check("alt_count", glog.size(), 4);
        end

        // Reset in the grant cycle aborts the operation.
        pulse_reset();
        req = 4'b1000;
        step(1);
        check("abort_gnt", int'(bus.o_gnt), 'b1000);
        rst = 1'b1;
        req[1] = 1'b1;
        step(1);
        check("abort_done", int'(bus.o_done), 0);
        check("abort_C",    int'(bus.o_C),    0);
        check("abort_busy", int'(bus.o_busy), 0);
        rst = 1'b0;
        oneshot = 4'b1010;
        step(1);
        check("abort_next", int'(bus.o_gnt), 'b0010);
        step(8);

        // Request raised while busy waits for the next idle edge.
        a[0] = 8'h12; b[0] = 8'h34; req[0] = 1'b1; oneshot[0] = 1'b1;
        step(1);
        check("late_gnt0", int'(bus.o_gnt), 'b0001);
        a[3] = 8'h55; b[3] = 8'hAA; req[3] = 1'b1; oneshot[3] = 1'b1;
        step(1);
        check("late_done0", int'(bus.o_done), 'b0001);
        check("late_C0",    int'(bus.o_C),    'h046);
        check("late_nog",   int'(bus.o_gnt),  0);
        step(1);
        check("late_idle", int'(bus.o_gnt), 0);
        step(1);
        check("late_gnt3", int'(bus.o_gnt), 'b1000);
        step(1);
        check("late_C3", int'(bus.o_C), 'h0FF);
        step(3);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
